// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave front-panel logic.
package microwave_pkg;

  localparam int unsigned KEY_W      = 10;
  localparam int unsigned KEY_CODE_W = 4;
  localparam int unsigned CNT1_W     = $clog2(KEY_W + 1);

  localparam logic BTN_IDLE   = 1'b1;
  localparam logic DOOR_RESET = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LOCKOUT
  } kp_state_t;

  function automatic logic [CNT1_W-1:0] popcount(input logic [KEY_W-1:0] vec);
    logic [CNT1_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      cnt = cnt + CNT1_W'(vec[i]);
    end
    return cnt;
  endfunction

  // OR-reduction encoder; only meaningful for a one-hot input.
  function automatic logic [KEY_CODE_W-1:0] onehot_to_bin(input logic [KEY_W-1:0] oh);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (oh[i]) begin
        idx = idx | KEY_CODE_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw front-panel inputs and their conditioned counterparts.
interface input_conditioner_if;

  logic [microwave_pkg::KEY_W-1:0]      raw_keys;
  logic                                 raw_startn;
  logic                                 raw_stopn;
  logic                                 raw_clearn;
  logic                                 raw_door_closed;

  logic [microwave_pkg::KEY_W-1:0]      keypad;
  logic                                 key_valid;
  logic [microwave_pkg::KEY_CODE_W-1:0] key_code;
  logic                                 startn;
  logic                                 stopn;
  logic                                 clearn;
  logic                                 door_closed;

  // Panel side: drives raw switches, observes conditioned outputs.
  modport master (
    output raw_keys, raw_startn, raw_stopn, raw_clearn, raw_door_closed,
    input  keypad, key_valid, key_code, startn, stopn, clearn, door_closed
  );

  // Conditioner side.
  modport slave (
    input  raw_keys, raw_startn, raw_stopn, raw_clearn, raw_door_closed,
    output keypad, key_valid, key_code, startn, stopn, clearn, door_closed
  );

endinterface

// File: rtl/debounce_channel.sv
// One synchronised, debounced input channel. FAST_FALL lets a 1->0 change through
// immediately after synchronisation while 0->1 still needs the full stable window.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter logic        RST_VAL         = 1'b0,
  parameter bit          FAST_FALL       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (FAST_FALL && !sync2_q) begin
        stable_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Fail-safe channels drop as soon as the synchronised level falls, one cycle ahead
  // of the registered stable state.
  assign stable = FAST_FALL ? (stable_q & sync2_q) : stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Front-panel conditioner: debounces keypad, buttons and door, and turns the keypad into
// a single-key one-hot vector with a one-shot accept strobe.
module input_conditioner
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic                clock,
  input logic                reset,
  input_conditioner_if.slave bus
);

  logic [KEY_W-1:0]      key_stable;
  logic [CNT1_W-1:0]     key_count;
  logic                  startn_s, stopn_s, clearn_s, door_s;

  kp_state_t             state_q, state_d;
  logic [KEY_W-1:0]      keypad_q, keypad_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (1'b0),
      .FAST_FALL      (1'b0)
    ) u_key (
      .clock (clock),
      .reset (reset),
      .raw   (bus.raw_keys[i]),
      .stable(key_stable[i])
    );
  end

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (BTN_IDLE),
    .FAST_FALL      (1'b0)
  ) u_start (
    .clock (clock),
    .reset (reset),
    .raw   (bus.raw_startn),
    .stable(startn_s)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (BTN_IDLE),
    .FAST_FALL      (1'b0)
  ) u_stop (
    .clock (clock),
    .reset (reset),
    .raw   (bus.raw_stopn),
    .stable(stopn_s)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (BTN_IDLE),
    .FAST_FALL      (1'b0)
  ) u_clear (
    .clock (clock),
    .reset (reset),
    .raw   (bus.raw_clearn),
    .stable(clearn_s)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (DOOR_RESET),
    .FAST_FALL      (1'b1)
  ) u_door (
    .clock (clock),
    .reset (reset),
    .raw   (bus.raw_door_closed),
    .stable(door_s)
  );

  assign key_count = popcount(key_stable);

  always_comb begin
    state_d     = state_q;
    keypad_d    = keypad_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_count == CNT1_W'(1)) begin
          state_d     = PRESSED;
          keypad_d    = key_stable;
          key_code_d  = onehot_to_bin(key_stable);
          key_valid_d = 1'b1;
        end else if (key_count >= CNT1_W'(2)) begin
          state_d = LOCKOUT;
        end
      end
      PRESSED: begin
        // Any change other than a clean release is treated as rollover.
        if (key_count == '0) begin
          state_d    = IDLE;
          keypad_d   = '0;
          key_code_d = '0;
        end else if (key_stable != keypad_q) begin
          state_d    = LOCKOUT;
          keypad_d   = '0;
          key_code_d = '0;
        end
      end
      LOCKOUT: begin
        if (key_count == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        keypad_d   = '0;
        key_code_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      keypad_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      keypad_q    <= keypad_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign bus.keypad      = keypad_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.startn      = startn_s;
  assign bus.stopn       = stopn_s;
  assign bus.clearn      = clearn_s;
  assign bus.door_closed = door_s;

  a_valid_single: assert property (@(posedge clock) disable iff (reset)
    key_valid_q |=> !key_valid_q);
  a_keypad_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(keypad_q));
  a_valid_has_key: assert property (@(posedge clock) disable iff (reset)
    key_valid_q |-> (keypad_q != '0));

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a window-based behavioural model.
module tb_input_conditioner;
  import microwave_pkg::*;

  localparam int unsigned DB   = 4;
  localparam int unsigned HIST = DB + 2;
  // Channel order: keys[9:0], startn, stopn, clearn, door.
  localparam logic [13:0] INACT = {1'b0, 3'b111, 10'b0};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  input_conditioner_if bus ();

  input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int kv_pulses = 0;

  // Model: raw history (h[0] = raw sampled at the latest edge) and accepted levels.
  logic [13:0] h [HIST];
  logic [13:0] m_stable;
  logic [9:0]  m_kp;
  logic [3:0]  m_code;
  logic        m_valid;
  int          m_mode;   // 0 waiting for key, 1 key held, 2 rollover lockout
  bit          m_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [13:0] rv;
    logic [9:0]  ks;
    int          s;
    bit          all_diff;
    rv = {bus.raw_door_closed, bus.raw_clearn, bus.raw_stopn, bus.raw_startn, bus.raw_keys};
    if (reset) begin
      for (int i = 0; i < HIST; i++) h[i] = INACT;
      m_stable = INACT;
      m_kp = '0; m_code = '0; m_valid = 1'b0; m_mode = 0; m_live = 1'b1;
    end else begin
      ks = m_stable[9:0];
      s = $countones(ks);
      m_valid = 1'b0;
      if (m_mode == 0) begin
        if (s == 1) begin
          m_mode = 1; m_kp = ks; m_valid = 1'b1;
          for (int i = 0; i < 10; i++) if (ks[i]) m_code = 4'(i);
        end else if (s > 1) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (s == 0) begin
          m_mode = 0; m_kp = '0; m_code = '0;
        end else if (ks != m_kp) begin
          m_mode = 2; m_kp = '0; m_code = '0;
        end
      end else if (s == 0) begin
        m_mode = 0;
      end
      for (int i = HIST - 1; i > 0; i--) h[i] = h[i-1];
      h[0] = rv;
      // A level is accepted once the last DB synchronised samples all disagree with it.
      for (int c = 0; c < 14; c++) begin
        all_diff = 1'b1;
        for (int k = 2; k < HIST; k++) if (h[k][c] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) m_stable[c] = ~m_stable[c];
        else if (c == 13 && m_stable[13] && !h[2][13]) m_stable[13] = 1'b0;
      end
    end
  endtask

  task automatic compare();
    if (!m_live) return;
    check("keypad", bus.keypad, m_kp);
    check("key_valid", bus.key_valid, m_valid);
    if (m_kp != '0) check("key_code", bus.key_code, m_code);
    check("startn", bus.startn, m_stable[10]);
    check("stopn", bus.stopn, m_stable[11]);
    check("clearn", bus.clearn, m_stable[12]);
    check("door_closed", bus.door_closed, m_stable[13] & h[1][13]);
    if (bus.key_valid === 1'b1) kv_pulses++;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  int kv0;

  initial begin
    bus.raw_keys = '0; bus.raw_startn = 1'b1; bus.raw_stopn = 1'b1;
    bus.raw_clearn = 1'b1; bus.raw_door_closed = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_keypad", bus.keypad, 10'h000);
    check("rst_startn", bus.startn, 1'b1);
    check("rst_door", bus.door_closed, 1'b0);

    // Clean press and release of key 5.
    kv0 = kv_pulses;
    bus.raw_keys = 10'h020;
    tick(6);  check("t1_kp_early", bus.keypad, 10'h000);
    tick(1);  check("t1_kp", bus.keypad, 10'h020);
    check("t1_code", bus.key_code, 4'd5);
    check("t1_valid", bus.key_valid, 1'b1);
    tick(13);
    bus.raw_keys = 10'h000;
    tick(6);  check("t1_rel_early", bus.keypad, 10'h020);
    tick(1);  check("t1_rel", bus.keypad, 10'h000);
    tick(5);  check("t1_pulses", kv_pulses - kv0, 1);

    // Bounce on key 0, then a clean hold.
    kv0 = kv_pulses;
    for (int i = 0; i < 6; i++) begin
      bus.raw_keys = (i % 2 == 0) ? 10'h001 : 10'h000;
      tick(2);
    end
    check("t2_bounce_kp", bus.keypad, 10'h000);
    check("t2_bounce_pulses", kv_pulses - kv0, 0);
    bus.raw_keys = 10'h001;
    tick(6);  check("t2_kp_early", bus.keypad, 10'h000);
    tick(1);  check("t2_kp", bus.keypad, 10'h001);
    check("t2_code", bus.key_code, 4'd0);
    tick(2);  check("t2_pulses", kv_pulses - kv0, 1);
    bus.raw_keys = 10'h000;
    tick(10);

    // Rollover: key 3, add key 7, release in turn, then key 2.
    kv0 = kv_pulses;
    bus.raw_keys = 10'h008;
    tick(7);  check("t3_kp3", bus.keypad, 10'h008);
    check("t3_code3", bus.key_code, 4'd3);
    bus.raw_keys = 10'h088;
    tick(6);  check("t3_roll_early", bus.keypad, 10'h008);
    tick(1);  check("t3_roll_kp", bus.keypad, 10'h000);
    check("t3_lockout", dut.state_q, LOCKOUT);
    bus.raw_keys = 10'h080;
    tick(10); check("t3_half_kp", bus.keypad, 10'h000);
    check("t3_half_pulses", kv_pulses - kv0, 1);
    bus.raw_keys = 10'h000;
    tick(10); check("t3_idle", dut.state_q, IDLE);
    bus.raw_keys = 10'h004;
    tick(7);  check("t3_kp2", bus.keypad, 10'h004);
    check("t3_code2", bus.key_code, 4'd2);
    bus.raw_keys = 10'h000;
    tick(10);

    // Door: debounced close, fast open, glitch.
    bus.raw_door_closed = 1'b1;
    tick(5);  check("t4_close_early", bus.door_closed, 1'b0);
    tick(1);  check("t4_close", bus.door_closed, 1'b1);
    tick(4);
    bus.raw_door_closed = 1'b0;
    tick(1);  check("t4_open_early", bus.door_closed, 1'b1);
    tick(1);  check("t4_open", bus.door_closed, 1'b0);
    bus.raw_door_closed = 1'b1;
    tick(8);  check("t4_reclose", bus.door_closed, 1'b1);
    bus.raw_door_closed = 1'b0;
    tick(1);
    bus.raw_door_closed = 1'b1;
    tick(1);  check("t4_glitch", bus.door_closed, 1'b0);
    tick(1);  check("t4_glitch_held", bus.door_closed, 1'b0);
    tick(3);  check("t4_glitch_rec_early", bus.door_closed, 1'b0);
    tick(1);  check("t4_glitch_rec", bus.door_closed, 1'b1);

    // Buttons: simultaneous start/stop, short clear pulse.
    bus.raw_startn = 1'b0; bus.raw_stopn = 1'b0;
    tick(5);  check("t5_start_early", bus.startn, 1'b1);
    check("t5_stop_early", bus.stopn, 1'b1);
    tick(1);  check("t5_start", bus.startn, 1'b0);
    check("t5_stop", bus.stopn, 1'b0);
    bus.raw_startn = 1'b1; bus.raw_stopn = 1'b1;
    tick(10);
    bus.raw_clearn = 1'b0;
    tick(3);
    bus.raw_clearn = 1'b1;
    tick(1);  check("t5_clear_a", bus.clearn, 1'b1);
    tick(8);  check("t5_clear_b", bus.clearn, 1'b1);

    // Reset while key 9 and start are held.
    bus.raw_keys = 10'h200; bus.raw_startn = 1'b0;
    tick(7);  check("t6_pre_kp", bus.keypad, 10'h200);
    check("t6_pre_start", bus.startn, 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_rst_kp", bus.keypad, 10'h000);
    check("t6_rst_valid", bus.key_valid, 1'b0);
    check("t6_rst_code", bus.key_code, 4'd0);
    check("t6_rst_start", bus.startn, 1'b1);
    check("t6_rst_stop", bus.stopn, 1'b1);
    check("t6_rst_clear", bus.clearn, 1'b1);
    check("t6_rst_door", bus.door_closed, 1'b0);
    tick(5);  check("t6_start_early", bus.startn, 1'b1);
    tick(1);  check("t6_start", bus.startn, 1'b0);
    check("t6_kp_early", bus.keypad, 10'h000);
    tick(1);  check("t6_kp", bus.keypad, 10'h200);
    check("t6_valid", bus.key_valid, 1'b1);
    bus.raw_keys = 10'h000; bus.raw_startn = 1'b1;
    tick(10);

    // Randomized traffic, model-checked every cycle.
    for (int it = 0; it < 300; it++) begin
      int r;
      logic [9:0] kv;
      r = $urandom_range(0, 9);
      kv = bus.raw_keys;
      if (r < 4) kv = '0;
      else if (r < 8) kv = 10'(1) << $urandom_range(0, 9);
      else if (r == 8) kv = (10'(1) << $urandom_range(0, 9)) | (10'(1) << $urandom_range(0, 9));
      else kv = kv ^ (10'(1) << $urandom_range(0, 9));
      bus.raw_keys = kv;
      if ($urandom_range(0, 3) == 0) bus.raw_startn = ~bus.raw_startn;
      if ($urandom_range(0, 3) == 0) bus.raw_stopn = ~bus.raw_stopn;
      if ($urandom_range(0, 3) == 0) bus.raw_clearn = ~bus.raw_clearn;
      if ($urandom_range(0, 3) == 0) bus.raw_door_closed = ~bus.raw_door_closed;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick($urandom_range(1, 10));
    end
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
